// File: rtl/vend_slot_sequencer.sv
// Vend slot sequencer: accepts one slot request at a time, checks the
// sold-out flag, drives the slot index to the decoder, lets it settle,
// pulses the shared motor and then waits for the drop sensor.
module vend_slot_sequencer #(
    parameter int SETTLE_CYCLES  = 2,
    parameter int PULSE_CYCLES   = 50,
    parameter int TIMEOUT_CYCLES = 200
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_slot,
    output logic        req_ready,
    input  logic [15:0] slot_empty,
    output logic [3:0]  slot_sel,
    output logic        motor_en,
    input  logic        drop_sensor,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic [1:0]  fault_code
);

    // One shared counter, sized for the longest phase.
    localparam int MAX_CYC = (SETTLE_CYCLES > PULSE_CYCLES)
                           ? ((SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES)
                           : ((PULSE_CYCLES  > TIMEOUT_CYCLES) ? PULSE_CYCLES  : TIMEOUT_CYCLES);
    localparam int CW = $clog2(MAX_CYC + 1);

    // Terminal counts: the counter starts at 0 on state entry.
    localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] PULSE_LAST   = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_EMPTY   = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        PULSE,
        WAIT_DROP,
        DONE,
        FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      slot_sel_q, slot_sel_d;
    logic [1:0]      fault_code_q, fault_code_d;
    logic            drop_q, drop_d;
    logic            motor_en_q, done_q, fault_q, busy_q;

    // Next-state, counter, slot latch and fault-code logic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q + CW'(1);
        slot_sel_d   = slot_sel_q;
        fault_code_d = fault_code_q;
        drop_d       = drop_q;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // req_ready is implied here: reset holds the registers anyway.
                if (req_valid) begin
                    slot_sel_d   = req_slot;
                    fault_code_d = CODE_NONE;
                    drop_d       = 1'b0;
                    if (slot_empty[req_slot]) begin
                        state_d      = FAULT;
                        fault_code_d = CODE_EMPTY;
                    end else begin
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end
            end
            PULSE: begin
                if (drop_sensor) begin
                    drop_d = 1'b1;
                end
                if (cnt_q == PULSE_LAST) begin
                    cnt_d   = '0;
                    state_d = (drop_q || drop_sensor) ? DONE : WAIT_DROP;
                end
            end
            WAIT_DROP: begin
                // A drop on the final timeout cycle still counts as success.
                if (drop_sensor) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d      = FAULT;
                    fault_code_d = CODE_TIMEOUT;
                    cnt_d        = '0;
                end
            end
            DONE, FAULT: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State register with registered outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            slot_sel_q   <= '0;
            fault_code_q <= CODE_NONE;
            drop_q       <= 1'b0;
            motor_en_q   <= 1'b0;
            done_q       <= 1'b0;
            fault_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_sel_q   <= slot_sel_d;
            fault_code_q <= fault_code_d;
            drop_q       <= drop_d;
            motor_en_q   <= (state_d == PULSE);
            done_q       <= (state_d == DONE);
            fault_q      <= (state_d == FAULT);
            busy_q       <= (state_d != IDLE);
        end
    end

    assign req_ready  = (state_q == IDLE) && !reset;
    assign slot_sel   = slot_sel_q;
    assign motor_en   = motor_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;

endmodule

// File: tb/tb_vend_slot_sequencer.sv
// Bench for vend_slot_sequencer: table of complete vends checked cycle by
// cycle, plus hand-written busy-rejection and mid-pulse reset sequences.
module tb_vend_slot_sequencer;

    localparam int S = 2;
    localparam int P = 4;
    localparam int T = 8;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic [3:0]  req_slot;
    logic        req_ready;
    logic [15:0] slot_empty;
    logic [3:0]  slot_sel;
    logic        motor_en;
    logic        drop_sensor;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_code;

    int n_checks = 0;
    int n_fail   = 0;

    vend_slot_sequencer #(
        .SETTLE_CYCLES (S),
        .PULSE_CYCLES  (P),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_slot   (req_slot),
        .req_ready  (req_ready),
        .slot_empty (slot_empty),
        .slot_sel   (slot_sel),
        .motor_en   (motor_en),
        .drop_sensor(drop_sensor),
        .busy       (busy),
        .done       (done),
        .fault      (fault),
        .fault_code (fault_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One complete vend: request, drop stimulus and the hand-computed outcome.
    typedef struct {
        logic [3:0]  slot;
        logic [15:0] empty;
        int          drop_cyc;   // cycle on which drop_sensor is 1, -1 for none
        int          end_cyc;    // cycle of the done/fault pulse
        logic        is_fault;
        logic [1:0]  code;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Apply one vector; cycle 0 is the accept edge, outputs sampled mid-cycle.
    task automatic run_vector(input int idx, input vec_t v);
        logic exp_motor;
        logic [1:0] exp_code;
        @(negedge clk);
        req_slot   = v.slot;
        slot_empty = v.empty;
        req_valid  = 1'b1;
        check($sformatf("v%0d ready_before_accept", idx), 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= v.end_cyc + 1; c++) begin
            @(negedge clk);
            exp_motor = !v.empty[v.slot] && (c >= S + 1) && (c <= S + P) && (c < v.end_cyc);
            if (c >= v.end_cyc) exp_code = v.code;
            else                exp_code = v.empty[v.slot] ? 2'b01 : 2'b00;
            check($sformatf("v%0d c%0d motor_en", idx, c), 32'(motor_en), 32'(exp_motor));
            check($sformatf("v%0d c%0d busy", idx, c), 32'(busy), 32'(c <= v.end_cyc));
            check($sformatf("v%0d c%0d req_ready", idx, c), 32'(req_ready), 32'(c > v.end_cyc));
            check($sformatf("v%0d c%0d done", idx, c), 32'(done), 32'(!v.is_fault && c == v.end_cyc));
            check($sformatf("v%0d c%0d fault", idx, c), 32'(fault), 32'(v.is_fault && c == v.end_cyc));
            check($sformatf("v%0d c%0d slot_sel", idx, c), 32'(slot_sel), 32'(v.slot));
            check($sformatf("v%0d c%0d fault_code", idx, c), 32'(fault_code), 32'(exp_code));
            drop_sensor = (c == v.drop_cyc);
        end
        drop_sensor = 1'b0;
    endtask

    initial begin
        bit seen;

        // slot, empty mask, drop cycle, end cycle, fault?, code
        vecs[0] = '{4'd5,  16'h0000,  8,  9, 1'b0, 2'b00}; // normal vend, drop in WAIT_DROP
        vecs[1] = '{4'd3,  16'h0000,  4,  7, 1'b0, 2'b00}; // drop during pulse
        vecs[2] = '{4'd15, 16'h8000, -1,  1, 1'b1, 2'b01}; // empty slot
        vecs[3] = '{4'd7,  16'h8000, -1, 15, 1'b1, 2'b10}; // timeout
        vecs[4] = '{4'd7,  16'h0000, 14, 15, 1'b0, 2'b00}; // drop on last timeout cycle wins
        vecs[5] = '{4'd0,  16'h8000,  6,  7, 1'b0, 2'b00}; // drop on last pulse cycle
        vecs[6] = '{4'd0,  16'h0001, -1,  1, 1'b1, 2'b01}; // empty slot 0
        vecs[7] = '{4'd9,  16'h0000,  2, 15, 1'b1, 2'b10}; // drop in SETTLE ignored -> timeout

        reset       = 1'b1;
        req_valid   = 1'b0;
        req_slot    = '0;
        slot_empty  = '0;
        drop_sensor = 1'b0;

        // Reset state while reset is held.
        repeat (2) @(negedge clk);
        check("rst req_ready", 32'(req_ready), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst motor_en", 32'(motor_en), 32'd0);
        check("rst slot_sel", 32'(slot_sel), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fault", 32'(fault), 32'd0);
        check("rst fault_code", 32'(fault_code), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_vector(i, vecs[i]);
        end

        // Busy rejection: slot 9 held during vend of slot 2 (drop cycle 5 -> done cycle 7).
        @(negedge clk);
        req_slot   = 4'd2;
        slot_empty = 16'h0000;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_slot = 4'd9;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            check($sformatf("busy_rej c%0d req_ready", c), 32'(req_ready), 32'd0);
            check($sformatf("busy_rej c%0d slot_sel", c), 32'(slot_sel), 32'd2);
            drop_sensor = (c == 5);
        end
        check("busy_rej c7 done", 32'(done), 32'd1);
        drop_sensor = 1'b0;
        @(negedge clk);
        check("busy_rej c8 req_ready", 32'(req_ready), 32'd1);
        check("busy_rej c8 slot_sel", 32'(slot_sel), 32'd2);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("b2b slot_sel", 32'(slot_sel), 32'd9);
        check("b2b busy", 32'(busy), 32'd1);
        drop_sensor = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check("b2b done within budget", 32'(seen), 32'd1);
        drop_sensor = 1'b0;
        @(negedge clk);
        check("b2b idle req_ready", 32'(req_ready), 32'd1);

        // Reset mid-pulse on cycle 4.
        @(negedge clk);
        req_slot   = 4'd4;
        slot_empty = 16'h0000;
        req_valid  = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid c4 motor_en before", 32'(motor_en), 32'd1);
        #1 reset = 1'b1;
        #1;
        check("rst_mid motor_en", 32'(motor_en), 32'd0);
        check("rst_mid busy", 32'(busy), 32'd0);
        check("rst_mid slot_sel", 32'(slot_sel), 32'd0);
        check("rst_mid req_ready", 32'(req_ready), 32'd0);
        check("rst_mid fault_code", 32'(fault_code), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || fault || motor_en || !req_ready) seen = 1'b1;
        end
        check("rst_mid quiet after release", 32'(seen), 32'd0);
        run_vector(8, vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
